// File: rtl/adld_pkg.sv
// Shared constants and FSM encoding for the adld sequencing controller.
package adld_pkg;
   localparam int W     = 3;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/adld_seq_ctrl_if.sv
// Requester, datapath and response signals of adld_seq_ctrl; slave is the controller side.
interface adld_seq_ctrl_if #(parameter int W = adld_pkg::W);
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic [W-1:0] dp_a_late, dp_b, dp_out;
   logic         resp_valid, resp_id, resp_ready, busy;
   logic [W-1:0] resp_data;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, dp_out, resp_ready,
      output req0_ready, req1_ready, dp_a_late, dp_b, resp_valid, resp_id, resp_data, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, dp_out, resp_ready,
      input  req0_ready, req1_ready, dp_a_late, dp_b, resp_valid, resp_id, resp_data, busy
   );
endinterface

// File: rtl/adld_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, pointer moves only on accept.
module adld_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_vld,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       grant_id
);
   logic last_q;

   // A lone requester always wins; on contention the one not served last wins.
   always_comb begin
      grant[0] = req_vld[0] & (~req_vld[1] | last_q);
      grant[1] = req_vld[1] & (~req_vld[0] | ~last_q);
      grant_id = grant[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_q <= 1'b1;
      else if (accept) last_q <= grant_id;
   end
endmodule

// File: rtl/adld_seq_ctrl.sv
// Arbitrates two requesters onto the shared late-arrival datapath, waits the
// settle time, captures dp_out and returns it with the requester id.
module adld_seq_ctrl #(
   parameter int W          = adld_pkg::W,
   parameter int SETTLE_CYC = 2
) (
   input logic           clk,
   input logic           rst_n,
   adld_seq_ctrl_if.slave bus
);
   import adld_pkg::*;

   localparam cnt_t CNT_LOAD = cnt_t'(SETTLE_CYC - 1);

   state_e       state, state_nxt;
   cnt_t         cnt_q;
   logic [1:0]   req_vld, grant;
   logic         grant_id, accept, idle;
   logic [W-1:0] dp_a_q, dp_b_q, resp_data_q;
   logic         resp_id_q, resp_valid_q;

   assign req_vld = {bus.req1_valid, bus.req0_valid};
   assign idle    = (state == IDLE);
   assign accept  = idle & (|grant);

   adld_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // RESP always returns to IDLE; a new grant is only evaluated the cycle after.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETTLE;
         SETTLE:  if (cnt_q == '0) state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = idle & grant[0];
      bus.req1_ready = idle & grant[1];
      bus.busy       = ~idle;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         dp_a_q       <= '0;
         dp_b_q       <= '0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            dp_a_q    <= grant_id ? bus.req1_a : bus.req0_a;
            dp_b_q    <= grant_id ? bus.req1_b : bus.req0_b;
            resp_id_q <= grant_id;
            cnt_q     <= CNT_LOAD;
         end
         if (state == SETTLE) begin
            if (cnt_q == '0) begin
               resp_data_q  <= bus.dp_out;
               resp_valid_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
         if (state == RESP && bus.resp_ready) resp_valid_q <= 1'b0;
      end
   end

   assign bus.dp_a_late  = dp_a_q;
   assign bus.dp_b       = dp_b_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_valid = resp_valid_q;
endmodule
